// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin or manual channel selection.
// A single output register stage gives one-cycle latency at full throughput.
module rr_stream_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  last_q, last_d;

    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  cand_idx;
    logic [WIDTH-1:0] grant_data;
    logic             accept;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (!mode) begin
            // Search starts just after the last served channel, wrapping modulo NCH.
            for (int unsigned k = 1; k <= NCH; k++) begin
                cand_idx = SELW'((32'(last_q) + k) % NCH);
                if (!grant_vld && in_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end else begin
            // An out-of-range sel matches no channel and simply grants nothing.
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = rst_n && load_en && grant_vld;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            last_d      = grant_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= SELW'(NCH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel instance for the main sequence
// and a 3-channel instance for out-of-range sel and non-power-of-two wrap.
module tb_rr_stream_mux;

    logic        clk;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int n_tests = 0;
    int n_fail  = 0;

    rr_stream_mux #(.WIDTH(8), .NCH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    rr_stream_mux #(.WIDTH(8), .NCH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_valid   = 4'hF;
        in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready  = 1'b1;
        mode3      = 1'b1;
        sel3       = 2'd3;
        in_valid3  = 3'b111;
        in_data3   = {8'hC2, 8'hC1, 8'hC0};
        out_ready3 = 1'b1;

        // Reset held for two cycles with every channel valid.
        cyc();
        cyc();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_ch", 32'(out_ch), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h0);

        // Round-robin over all four channels, starting at channel 0.
        rst_n = 1'b1;
        #1;
        check_eq("rr_first_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq("rr_out_ch", 32'(out_ch), 32'(k % 4));
            check_eq("rr_out_data", 32'(out_data), 32'(8'hA0 + k % 4));
            check_eq("rr_out_valid", 32'(out_valid), 32'd1);
            if (k < 5) @(posedge clk);
        end

        // Sparse: channels 1 and 3 only; last = 1 so 3 is served first.
        in_valid = 4'b1010;
        #1;
        check_eq("sp_ready_pre", 32'(in_ready), 32'b1000);
        cyc();
        check_eq("sp_out_ch_pre", 32'(out_ch), 32'd3);
        for (int k = 0; k < 4; k++) begin
            check_eq("sp_in_ready", 32'(in_ready), (k % 2 == 0) ? 32'b0010 : 32'b1000);
            cyc();
            check_eq("sp_out_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
            check_eq("sp_out_valid", 32'(out_valid), 32'd1);
        end

        // Manual select of channel 2 with all channels valid.
        mode     = 1'b1;
        sel      = 2'd2;
        in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("man_in_ready", 32'(in_ready), 32'b0100);
            cyc();
            check_eq("man_out_ch", 32'(out_ch), 32'd2);
            check_eq("man_out_data", 32'(out_data), 32'hA2);
        end
        in_valid = 4'b1011;
        #1;
        check_eq("man_drop_ready", 32'(in_ready), 32'h0);
        cyc();
        check_eq("man_drop_valid", 32'(out_valid), 32'd0);
        check_eq("man_drop_ch_hold", 32'(out_ch), 32'd2);
        check_eq("man_drop_data_hold", 32'(out_data), 32'hA2);
        cyc();
        check_eq("man_drop_valid2", 32'(out_valid), 32'd0);

        // Back to round-robin: continues after channel 2.
        mode     = 1'b0;
        in_valid = 4'hF;
        #1;
        check_eq("sw_in_ready", 32'(in_ready), 32'b1000);
        cyc();
        check_eq("sw_out_ch", 32'(out_ch), 32'd3);
        check_eq("sw_out_data", 32'(out_data), 32'hA3);

        // Backpressure on a channel-1 word of 0x5A.
        mode           = 1'b1;
        sel            = 2'd1;
        in_data[15:8]  = 8'h5A;
        cyc();
        check_eq("bp_load_ch", 32'(out_ch), 32'd1);
        check_eq("bp_load_data", 32'(out_data), 32'h5A);
        out_ready = 1'b0;
        sel       = 2'd2;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("bp_in_ready", 32'(in_ready), 32'h0);
            cyc();
            check_eq("bp_hold_data", 32'(out_data), 32'h5A);
            check_eq("bp_hold_ch", 32'(out_ch), 32'd1);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(in_ready), 32'b0100);
        cyc();
        check_eq("bp_next_valid", 32'(out_valid), 32'd1);
        check_eq("bp_next_ch", 32'(out_ch), 32'd2);
        check_eq("bp_next_data", 32'(out_data), 32'hA2);

        // Reset while stalled drops the held word and rewinds the pointer.
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("mrst_in_ready", 32'(in_ready), 32'h0);
        cyc();
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_out_data", 32'(out_data), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        mode      = 1'b0;
        #1;
        check_eq("mrst_first_ready", 32'(in_ready), 32'b0001);
        cyc();
        check_eq("mrst_first_ch", 32'(out_ch), 32'd0);

        // Three-channel instance: sel = 3 is out of range and grants nothing.
        check_eq("n3_sel3_ready", 32'(in_ready3), 32'h0);
        check_eq("n3_sel3_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd2;
        #1;
        check_eq("n3_sel2_ready", 32'(in_ready3), 32'b100);
        cyc();
        check_eq("n3_sel2_ch", 32'(out_ch3), 32'd2);
        check_eq("n3_sel2_data", 32'(out_data3), 32'hC2);
        mode3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("n3_rr_ready", 32'(in_ready3), 32'(1 << (k % 3)));
            cyc();
            check_eq("n3_rr_ch", 32'(out_ch3), 32'(k % 3));
            check_eq("n3_rr_data", 32'(out_data3), 32'(8'hC0 + k % 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
